// File: rtl/board_move_if.sv
// rtl/board_move_if.sv - board_move control and status bundle
interface board_move_if;
  logic        load;
  logic [63:0] board_in;
  logic        start;
  logic [1:0]  dir;
  logic [63:0] board;
  logic        busy;
  logic        done;
  logic        moved;
  logic [3:0]  merge_cnt;
  logic        win;
  logic        lose;

  modport master (
    output load, board_in, start, dir,
    input  board, busy, done, moved, merge_cnt, win, lose
  );

  modport slave (
    input  load, board_in, start, dir,
    output board, busy, done, moved, merge_cnt, win, lose
  );
endinterface

// File: rtl/board_move.sv
// rtl/board_move.sv - 2048 board move engine: one line per cycle, then spawn
module board_move (
  input  logic         clk,
  input  logic         rst,
  board_move_if.slave  bm
);

  typedef enum logic [2:0] {IDLE, LINE0, LINE1, LINE2, LINE3, SPAWN} state_t;

  state_t      state, state_nx;
  logic [63:0] board_q, work, work_nx, spawn_board;
  logic [1:0]  dir_q;
  logic        busy_q, done_q, moved_q, win_q, lose_c;
  logic [3:0]  merge_q;
  logic [15:0] lfsr;
  logic        do_load, do_start, line_act, spawn_act, changed;
  logic [1:0]  line_k;
  logic [15:0] line_in, line_out;
  logic [1:0]  line_cnt;

  // position p of line k maps to a board index; position 0 is the slide target
  function automatic logic [3:0] cell_idx(input logic [1:0] d, input logic [1:0] k,
                                          input logic [1:0] p);
    case (d)
      2'b00:   return {p, k};
      2'b01:   return {~p, k};
      2'b10:   return {k, p};
      default: return {k, ~p};
    endcase
  endfunction

  function automatic logic [17:0] compress(input logic [15:0] ln);
    logic [15:0] packed_v, o;
    logic [3:0]  t [5];
    logic [2:0]  n, j;
    logic [1:0]  c;
    logic        skip;
    packed_v = '0;
    n = '0;
    for (int i = 0; i < 4; i++) begin
      if (ln[4*i +: 4] != 4'd0) begin
        packed_v = packed_v | ({12'd0, ln[4*i +: 4]} << {n, 2'b00});
        n = n + 3'd1;
      end
    end
    for (int i = 0; i < 4; i++) t[i] = packed_v[4*i +: 4];
    t[4] = 4'd0;
    o = '0;
    j = '0;
    c = '0;
    skip = 1'b0;
    // exponent 15 never merges so the result cannot wrap
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (t[i] != 4'd0 && t[i] == t[i+1] && t[i] != 4'hF) begin
        o = o | ({12'd0, t[i] + 4'd1} << {j, 2'b00});
        j = j + 3'd1;
        c = c + 2'd1;
        skip = 1'b1;
      end else begin
        o = o | ({12'd0, t[i]} << {j, 2'b00});
        j = j + 3'd1;
      end
    end
    return {c, o};
  endfunction

  function automatic logic has11(input logic [63:0] b);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 16; i++) if (b[4*i +: 4] == 4'd11) r = 1'b1;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!bm.load && bm.start) state_nx = LINE0;
      LINE0:   state_nx = LINE1;
      LINE1:   state_nx = LINE2;
      LINE2:   state_nx = LINE3;
      LINE3:   state_nx = SPAWN;
      SPAWN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    do_load   = 1'b0;
    do_start  = 1'b0;
    line_act  = 1'b0;
    spawn_act = 1'b0;
    line_k    = 2'd0;
    case (state)
      IDLE: begin
        do_load  = bm.load;
        do_start = bm.start && !bm.load;
      end
      LINE0:   begin line_act = 1'b1; line_k = 2'd0; end
      LINE1:   begin line_act = 1'b1; line_k = 2'd1; end
      LINE2:   begin line_act = 1'b1; line_k = 2'd2; end
      LINE3:   begin line_act = 1'b1; line_k = 2'd3; end
      SPAWN:   spawn_act = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    line_in = '0;
    for (int p = 0; p < 4; p++)
      line_in[4*p +: 4] = work[{cell_idx(dir_q, line_k, 2'(p)), 2'b00} +: 4];
    {line_cnt, line_out} = compress(line_in);
    work_nx = work;
    for (int p = 0; p < 4; p++)
      work_nx[{cell_idx(dir_q, line_k, 2'(p)), 2'b00} +: 4] = line_out[4*p +: 4];
  end

  always_comb begin
    logic [3:0] c;
    logic       found;
    c = '0;
    found = 1'b0;
    spawn_board = work;
    for (int i = 0; i < 16; i++) begin
      c = lfsr[3:0] + 4'(i);
      if (!found && work[{c, 2'b00} +: 4] == 4'd0) begin
        found = 1'b1;
        spawn_board[{c, 2'b00} +: 4] = (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
      end
    end
  end

  assign changed = (work != board_q);

  always_comb begin
    lose_c = 1'b1;
    for (int i = 0; i < 16; i++) if (board_q[4*i +: 4] == 4'd0) lose_c = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (board_q[4*(4*r+c) +: 4] == board_q[4*(4*r+c+1) +: 4] &&
            board_q[4*(4*r+c) +: 4] != 4'hF) lose_c = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        if (board_q[4*(4*r+c) +: 4] == board_q[4*(4*r+c+4) +: 4] &&
            board_q[4*(4*r+c) +: 4] != 4'hF) lose_c = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      board_q <= '0;
      work    <= '0;
      dir_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      moved_q <= 1'b0;
      merge_q <= '0;
      win_q   <= 1'b0;
      lfsr    <= 16'hACE1;
    end else begin
      lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      done_q <= 1'b0;
      if (do_load) begin
        board_q <= bm.board_in;
        win_q   <= has11(bm.board_in);
      end
      if (do_start) begin
        dir_q   <= bm.dir;
        work    <= board_q;
        merge_q <= '0;
        busy_q  <= 1'b1;
      end
      if (line_act) begin
        work    <= work_nx;
        merge_q <= merge_q + {2'b00, line_cnt};
      end
      if (spawn_act) begin
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        moved_q <= changed;
        if (changed) begin
          board_q <= spawn_board;
          win_q   <= has11(spawn_board);
        end
      end
    end
  end

  assign bm.board     = board_q;
  assign bm.busy      = busy_q;
  assign bm.done      = done_q;
  assign bm.moved     = moved_q;
  assign bm.merge_cnt = merge_q;
  assign bm.win       = win_q;
  assign bm.lose      = lose_c;

endmodule

// File: tb/tb_board_move.sv
// tb/tb_board_move.sv - scoreboard bench for board_move
module tb_board_move;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  board_move_if bm ();

  board_move dut (
    .clk (clk),
    .rst (rst),
    .bm  (bm)
  );

  typedef struct {
    logic [63:0] board;
    logic [3:0]  mc;
    logic        moved;
    logic        win;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [15:0] m_lfsr;

  localparam logic [63:0] CHK = 64'h1212_2121_1212_2121;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [63:0] spawn_model(input logic [63:0] b, input logic [15:0] l);
    logic [63:0] r;
    int          idx;
    r = b;
    for (int i = 0; i < 16; i++) begin
      idx = (int'(l[3:0]) + i) % 16;
      if (r[4*idx +: 4] == 4'd0) begin
        r[4*idx +: 4] = (l[7:4] == 4'd0) ? 4'd2 : 4'd1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic win_model(input logic [63:0] b);
    for (int i = 0; i < 16; i++) if (b[4*i +: 4] == 4'd11) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_lfsr <= rst ? 16'hACE1 : lfsr_step(m_lfsr);
  end

  always @(negedge clk) begin
    if (bm.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check_val("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val({e.tag, "_board"}, bm.board, e.board);
        check_val({e.tag, "_merge_cnt"}, bm.merge_cnt, e.mc);
        check_val({e.tag, "_moved"}, bm.moved, e.moved);
        check_val({e.tag, "_win"}, bm.win, e.win);
        check_val({e.tag, "_latency"}, cyc, e.cyc);
        check_val({e.tag, "_busy_clear"}, bm.busy, 0);
      end
    end
  end

  task automatic load_board(input logic [63:0] b);
    @(negedge clk);
    bm.load = 1'b1;
    bm.board_in = b;
    @(negedge clk);
    bm.load = 1'b0;
  endtask

  // caller sits on a negedge; the next posedge samples start
  task automatic push_start(input string tag, input logic [1:0] d, input logic [63:0] pre,
                            input logic [3:0] mc, input logic mv);
    exp_t        e;
    logic [15:0] l;
    bm.start = 1'b1;
    bm.dir = d;
    l = m_lfsr;
    repeat (5) l = lfsr_step(l);
    e.board = mv ? spawn_model(pre, l) : pre;
    e.mc = mc;
    e.moved = mv;
    e.win = win_model(e.board);
    e.cyc = cyc + 6;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    check_val({tag, "_done_seen"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_move(input string tag, input logic [63:0] b, input logic [1:0] d,
                          input logic [63:0] pre, input logic [3:0] mc, input logic mv);
    load_board(b);
    push_start(tag, d, pre, mc, mv);
    @(negedge clk);
    bm.start = 1'b0;
    wait_idle(tag);
  endtask

  initial begin
    int d0;
    bm.load = 1'b0;
    bm.start = 1'b0;
    bm.dir = 2'b00;
    bm.board_in = '0;
    repeat (3) @(negedge clk);
    check_val("rst_board", bm.board, 0);
    check_val("rst_busy", bm.busy, 0);
    check_val("rst_done", bm.done, 0);
    check_val("rst_moved", bm.moved, 0);
    check_val("rst_merge_cnt", bm.merge_cnt, 0);
    check_val("rst_win", bm.win, 0);
    check_val("rst_lose", bm.lose, 0);
    rst = 1'b0;

    run_move("left_1111",   64'h0000_0000_0000_1111, 2'b10, 64'h0000_0000_0000_0022, 4'd2, 1'b1);
    run_move("up_col0",     64'h0000_0000_0001_0001, 2'b00, 64'h0000_0000_0000_0002, 4'd1, 1'b1);
    run_move("left_nochg",  64'h0000_0000_0000_0021, 2'b10, 64'h0000_0000_0000_0021, 4'd0, 1'b0);
    run_move("left_ff",     64'h0000_0000_0000_00FF, 2'b10, 64'h0000_0000_0000_00FF, 4'd0, 1'b0);
    run_move("left_aa_win", 64'h0000_0000_0000_00AA, 2'b10, 64'h0000_0000_0000_000B, 4'd1, 1'b1);
    run_move("right_0011",  64'h0000_0000_0000_0011, 2'b11, 64'h0000_0000_0000_2000, 4'd1, 1'b1);
    run_move("down_col0",   64'h0001_0000_0000_0001, 2'b01, 64'h0002_0000_0000_0000, 4'd1, 1'b1);
    run_move("left_triple", 64'h0000_0000_0000_0111, 2'b10, 64'h0000_0000_0000_0012, 4'd1, 1'b1);
    run_move("left_2211",   64'h0000_0000_0000_1122, 2'b10, 64'h0000_0000_0000_0023, 4'd2, 1'b1);
    run_move("rows_all",    64'h1111_0220_3300_0101, 2'b10,
             64'h0022_0003_0004_0002, 4'd5, 1'b1);
    run_move("chk_left",    CHK, 2'b10, CHK, 4'd0, 1'b0);

    load_board(CHK);
    check_val("lose_checker", bm.lose, 1);
    load_board(64'hFFFF_FFFF_FFFF_FFFF);
    check_val("lose_all15", bm.lose, 1);
    load_board(64'h1212_2121_1212_2111);
    check_val("lose_pair", bm.lose, 0);
    load_board(64'h0000_0000_0000_1111);
    check_val("lose_empty", bm.lose, 0);

    d0 = done_cnt;
    push_start("busy_start", 2'b10, 64'h0000_0000_0000_0022, 4'd2, 1'b1);
    @(negedge clk);
    bm.start = 1'b0;
    @(negedge clk);
    bm.start = 1'b1;
    bm.dir = 2'b11;
    @(negedge clk);
    bm.start = 1'b0;
    wait_idle("busy_start");
    repeat (8) @(negedge clk);
    check_val("busy_one_done", done_cnt - d0, 1);

    d0 = done_cnt;
    load_board(64'h0000_0000_0000_1111);
    bm.start = 1'b1;
    bm.dir = 2'b10;
    @(negedge clk);
    bm.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("line2_busy", bm.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_board", bm.board, 0);
    check_val("abort_busy", bm.busy, 0);
    check_val("abort_merge_cnt", bm.merge_cnt, 0);
    repeat (10) @(negedge clk);
    check_val("abort_no_done", done_cnt - d0, 0);

    d0 = done_cnt;
    @(negedge clk);
    bm.load = 1'b1;
    bm.start = 1'b1;
    bm.board_in = 64'h0000_0000_0000_0303;
    @(negedge clk);
    bm.load = 1'b0;
    bm.start = 1'b0;
    check_val("ldst_busy", bm.busy, 0);
    check_val("ldst_board", bm.board, 64'h0000_0000_0000_0303);
    repeat (8) @(negedge clk);
    check_val("ldst_no_done", done_cnt - d0, 0);
    check_val("ldst_board_hold", bm.board, 64'h0000_0000_0000_0303);

    check_val("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
